// File: rtl/multi_16bit_shift_add_pkg.sv
// Shared arithmetic-library constants and the multiplier state encoding.
package arith_pkg;

    localparam int MUL_IN_W  = 16;
    localparam int MUL_OUT_W = 32;
    localparam int MUL_ITER  = 16;
    localparam int CNT_W     = 5;

    localparam logic [CNT_W-1:0] MUL_LAST_CNT = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/multi_16bit_shift_add_if.sv
// Request/result bus of the shift-add multiplier; master drives operands, slave returns the product.
interface multi_16bit_shift_add_if;
    import arith_pkg::*;

    logic                 start;
    logic [MUL_IN_W-1:0]  ain;
    logic [MUL_IN_W-1:0]  bin;
    logic                 busy;
    logic                 done;
    logic [MUL_OUT_W-1:0] yout;
    logic                 c32;

    modport master (output start, ain, bin, input busy, done, yout, c32);
    modport slave  (input start, ain, bin, output busy, done, yout, c32);
endinterface

// File: rtl/multi_16bit_shift_add_adder.sv
// 32-bit adder built from 4-bit carry-lookahead groups, carry-in tied to 0.
module verified_adder_32bit (
    input  logic [32:1] A,
    input  logic [32:1] B,
    output logic [32:1] S,
    output logic        C32
);

    logic [32:1] g_s;
    logic [32:1] p_s;
    logic [32:0] c_s;

    // carries out of each bit of a 4-bit group, flattened lookahead terms
    function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] co;
        co[0] = g[0] | (p[0] & ci);
        co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
        return co;
    endfunction

    assign g_s = A & B;
    assign p_s = A ^ B;

    // group carries chain between lookahead blocks
    always_comb begin
        c_s      = 33'd0;
        c_s[0]   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c_s[4*k+4 -: 4] = cla4(g_s[4*k+4 -: 4], p_s[4*k+4 -: 4], c_s[4*k]);
        end
    end

    assign S   = p_s ^ c_s[31:0];
    assign C32 = c_s[32];

endmodule

// File: rtl/multi_16bit_shift_add.sv
// Sequential 16x16 unsigned multiplier: one partial product per clock through the 32-bit adder.
module multi_16bit_shift_add
    import arith_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multi_16bit_shift_add_if.slave  bus
);

    mul_state_e           state_q, state_d;
    logic [MUL_OUT_W-1:0] mcand_q, mcand_d;
    logic [MUL_IN_W-1:0]  mplr_q,  mplr_d;
    logic [MUL_OUT_W-1:0] prod_q,  prod_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    logic [32:1] add_a_s;
    logic [32:1] add_b_s;
    logic [32:1] add_s_s;
    logic        add_c32_s;

    assign add_a_s = prod_q;
    assign add_b_s = mplr_q[0] ? mcand_q : 32'd0;

    verified_adder_32bit u_adder (
        .A   (add_a_s),
        .B   (add_b_s),
        .S   (add_s_s),
        .C32 (add_c32_s)
    );

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= 32'd0;
            mplr_q  <= 16'd0;
            prod_q  <= 32'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state logic; DONE accepts a new request just like IDLE for back-to-back use
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    mcand_d = {16'd0, bus.ain};
                    mplr_d  = bus.bin;
                    prod_d  = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prod_d  = add_s_s;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == MUL_LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);
    assign bus.yout = prod_q;
    assign bus.c32  = add_c32_s;

endmodule

// File: doc/multi_16bit_shift_add.md
# multi_16bit_shift_add

Sequential 16×16 unsigned multiplier that uses the team's 32-bit carry-lookahead adder as its only arithmetic element. It accumulates one partial product per clock through the adder, so a full product takes 16 iterations. It sits directly upstream of the adder, generating both operands every cycle and consuming its sum. It is the first multi-cycle arithmetic unit in the Arithmetic library.

## Interface
Parameters:
- none. Widths are fixed by the 32-bit adder; constants live in the package.

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request pulse; sampled only when busy=0
- ain  in  16  multiplicand, unsigned
- bin  in  16  multiplier, unsigned
- busy  out  1  high while iterating; start is ignored
- done  out  1  one-cycle pulse; yout holds the final product
- yout  out  32  product register, unsigned

## Operation
- State machine states: IDLE, CALC, DONE.
- Registers:
  - mcand (32b): ain zero-extended, shifted left once per iteration.
  - mplr (16b): bin, shifted right once per iteration.
  - prod (32b): running product; drives yout.
  - cnt (5b): iteration counter.
- IDLE:
  - start=1 captures ain into mcand and bin into mplr, clears prod to 0, clears cnt to 0, and moves to CALC.
  - start=0 leaves the state and all registers unchanged.
- CALC, each cycle:
  - Adder operands are A=prod and B = mplr[0] ? mcand : 0.
  - prod <= adder S.
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt + 1.
  - When cnt=15 (the 16th iteration), move to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 in this cycle is accepted exactly as in IDLE and moves to CALC, giving back-to-back operation.
  - Otherwise move to IDLE.
- Arithmetic:
  - The adder carry-in is fixed at 0.
  - C32 is unused: a 16×16 product never exceeds 32 bits, so C32 is always 0.
  - Adder carry-out high is a design error.
- Iteration count is always 16 regardless of operand values; there is no early termination.
- start while busy=1 is ignored with no side effect. ain and bin are not required to be stable after the accept edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, yout=0, mcand=0, mplr=0, cnt=0.
- Reset assertion at any point, including mid-CALC, returns all of the above immediately; the partial result is discarded.
- Latency, with the accept edge as edge N:
  - busy=1 from after edge N through after edge N+15.
  - done=1 and busy=0 in the cycle after edge N+16.
  - The next start can be accepted at edge N+17.
  - Throughput is one product per 17 cycles.
- yout changes every CALC cycle; it is valid only from the done cycle onward.
- yout holds its value through IDLE until the next accept edge clears it.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Structure
- Shared package (arith_pkg) holds:
  - MUL_IN_W=16, MUL_OUT_W=32, MUL_ITER=16, CNT_W=5.
  - The state enum {IDLE, CALC, DONE}.
- One sub-module: the existing 32-bit adder (verified_adder_32bit), instantiated once, with ports A, B, S, C32 indexed [32:1].
- Everything else (FSM, shift registers, counter) stays in this module.

## Test plan
- Small operands: ain=3, bin=5, start pulse at edge N → done at cycle N+16, yout=0x0000000F.
- Maximum operands: ain=0xFFFF, bin=0xFFFF → yout=0xFFFE0001; C32 stays 0 on every cycle.
- Zero operand: ain=0x1234, bin=0 → still 16 busy cycles, done asserts, yout=0.
- Start while busy: start=1 with ain=7, bin=7 at cycle N+5 during a 3×5 operation → ignored; yout=15 at done; no second done.
- Reset mid-operation: rst_n low at cycle N+8 → busy=0, done=0, yout=0 immediately. A new 0x00FF×0x0101 after release → 0x0000FFFF.
- Back-to-back: start held high through the DONE cycle with ain=2, bin=0x8000 → first done reports the prior result. The second operation begins at edge N+17 and yields 0x00010000 at its done.
